// File: rtl/imm_chunker_pkg.sv
// Shared constants, range limits and FSM states for the 14-bit immediate encoder.
package imm_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IMM_W      = 14;
  localparam int unsigned MAX_CHUNKS = 3;

  localparam int IMM1_MIN = -(2 ** 13);
  localparam int IMM1_MAX = (2 ** 13) - 1;
  localparam int IMM2_MIN = -(2 ** 27);
  localparam int IMM2_MAX = (2 ** 27) - 1;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/imm_chunker_if.sv
// Constant-in / immediate-out handshake bundle for imm_chunker.
interface imm_chunker_if #(
  parameter int unsigned DATA_W = imm_pkg::DATA_W,
  parameter int unsigned IMM_W  = imm_pkg::IMM_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IMM_W-1:0]  out_imm;
  logic              out_first;
  logic              out_last;
  logic [1:0]        out_count;

  // Source/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_imm, out_first, out_last, out_count
  );

  // Chunker side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_imm, out_first, out_last, out_count
  );

endinterface

// File: rtl/imm_fit_check.sv
// Combinational chunk-count and chunk-value computation for one constant.
module imm_fit_check #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 14
) (
  input  logic [DATA_W-1:0] data,
  output logic [1:0]        n_chunks,
  output logic [IMM_W-1:0]  chunk_hi,
  output logic [IMM_W-1:0]  chunk_mid,
  output logic [IMM_W-1:0]  chunk_lo
);
  import imm_pkg::*;

  logic signed [DATA_W-1:0] v;

  assign v = data;

  always_comb begin
    if (v >= IMM1_MIN && v <= IMM1_MAX) begin
      n_chunks = 2'd1;
    end else if (v >= IMM2_MIN && v <= IMM2_MAX) begin
      n_chunks = 2'd2;
    end else begin
      n_chunks = 2'd3;
    end
  end

  // Top chunk is the 3*IMM_W-bit sign extension of data, upper field.
  assign chunk_hi  = {{(3 * IMM_W - DATA_W){data[DATA_W-1]}}, data[DATA_W-1:2*IMM_W]};
  assign chunk_mid = data[2*IMM_W-1:IMM_W];
  assign chunk_lo  = data[IMM_W-1:0];

endmodule

// File: rtl/imm_chunker.sv
// Splits a constant into 1-3 sign-extendable immediates, most-significant chunk first.
module imm_chunker #(
  parameter int unsigned DATA_W = imm_pkg::DATA_W,
  parameter int unsigned IMM_W  = imm_pkg::IMM_W
) (
  input logic          clk,
  input logic          reset,
  imm_chunker_if.slave bus
);
  import imm_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       remaining_q, remaining_d;
  logic [1:0]       count_q, count_d;
  logic [IMM_W-1:0] hi_q, hi_d, mid_q, mid_d, lo_q, lo_d;

  logic [1:0]       fit_n;
  logic [IMM_W-1:0] fit_hi, fit_mid, fit_lo;
  logic             emitting;
  logic             accept;

  imm_fit_check #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_fit (
    .data      (bus.in_data),
    .n_chunks  (fit_n),
    .chunk_hi  (fit_hi),
    .chunk_mid (fit_mid),
    .chunk_lo  (fit_lo)
  );

  assign emitting = (state_q == ST_EMIT);

  // A new constant may enter in the same cycle the last chunk is taken.
  assign bus.in_ready = !reset &&
                        (!emitting || (remaining_q == 2'd1 && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = emitting;
  assign bus.out_first = emitting && (remaining_q == count_q);
  assign bus.out_last  = emitting && (remaining_q == 2'd1);
  assign bus.out_count = count_q;

  // remaining counts down 3/2/1, selecting hi/mid/lo respectively.
  always_comb begin
    bus.out_imm = '0;
    case (remaining_q)
      2'd3:    bus.out_imm = hi_q;
      2'd2:    bus.out_imm = mid_q;
      2'd1:    bus.out_imm = lo_q;
      default: bus.out_imm = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    hi_d        = hi_q;
    mid_d       = mid_q;
    lo_d        = lo_q;
    if (accept) begin
      state_d     = ST_EMIT;
      remaining_d = fit_n;
      count_d     = fit_n;
      hi_d        = fit_hi;
      mid_d       = fit_mid;
      lo_d        = fit_lo;
    end else if (emitting && bus.out_ready) begin
      if (remaining_q > 2'd1) begin
        remaining_d = remaining_q - 2'd1;
      end else begin
        state_d     = ST_IDLE;
        remaining_d = 2'd0;
        count_d     = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 2'd0;
      count_q     <= 2'd0;
      hi_q        <= '0;
      mid_q       <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      mid_q       <= mid_d;
      lo_q        <= lo_d;
    end
  end

endmodule

// File: doc/imm_chunker.md
# imm_chunker

Splits a 32-bit constant into the minimum number of 14-bit immediate fields that the `signextend` datapath can reassemble. It is the encode side of the 14-bit immediate format. It sits between the constant source (assembler/loader or the constant-materialization unit) and the instruction-issue path, and emits one immediate per handshake, most-significant chunk first. The receiver rebuilds the value as `acc = sext14(first)`, then `acc = (acc << 14) | chunk` for each following chunk.

## Interface
Parameters:
- `DATA_W`, 32: input constant width.
- `IMM_W`, 14: immediate field width. Only the default pair (32/14) is verified.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the block accepts a new constant this cycle.
- `in_data`, in, 32: constant to encode, two's complement.
- `out_valid`, out, 1: `out_imm` is valid.
- `out_ready`, in, 1: the consumer takes the chunk.
- `out_imm`, out, 14: current immediate chunk.
- `out_first`, out, 1: this chunk is the first of its constant (the receiver sign-extends it).
- `out_last`, out, 1: this chunk is the final chunk of its constant.
- `out_count`, out, 2: total chunk count N (1 to 3) of the current constant. Stable for the whole sequence.

## Operation
- Chunk count, computed on the input value v:
  - N = 1 if -8192 ≤ v ≤ 8191.
  - N = 2 if -2^27 ≤ v ≤ 2^27-1.
  - N = 3 otherwise.
- Chunk values, with s = sext42(v):
  - N = 3: chunks are s[41:28], then v[27:14], then v[13:0].
  - N = 2: chunks are v[27:14], then v[13:0].
  - N = 1: the single chunk is v[13:0].
- State machine:
  - IDLE: `in_ready`=1.
    - On `in_valid`: latch `in_data`, compute N, load `remaining`=N, go to EMIT.
  - EMIT: `out_valid`=1.
    - On `out_valid && out_ready` with `remaining` > 1: decrement `remaining` and advance to the next chunk.
    - On `out_valid && out_ready` with `remaining` = 1: go to IDLE, unless a new constant is accepted in the same cycle, in which case stay in EMIT with the new constant.
- Back-to-back: `in_ready` = (state == IDLE) OR (state == EMIT AND `out_last` AND `out_ready`).
  - A new constant can be accepted in the cycle its predecessor's last chunk is consumed, with no bubble.
- Flag derivation:
  - `out_first` = (`remaining` == N).
  - `out_last` = (`remaining` == 1).
- Output stability: while `out_valid` && !`out_ready`, `out_imm`, `out_first`, `out_last` and `out_count` hold stable. `in_data` is ignored.
- Arithmetic: all range tests are signed compares on `in_data`. No saturation is needed, because every 32-bit value fits in 3 chunks.

## Timing
- Reset values (asynchronous, immediate on assertion):
  - state = IDLE
  - `out_valid`=0, `out_imm`=0, `out_first`=0, `out_last`=0, `out_count`=0
  - `remaining`=0
- `in_ready` is 0 while `reset` is asserted and 1 from the first cycle after deassertion.
- Latency: a constant accepted at edge k presents its first chunk in the cycle after edge k.
- Throughput: N cycles per constant when `out_ready` is held at 1.
- Reset mid-sequence: the in-flight constant is dropped and no partial chunks appear after reset. The consumer must discard any partially built accumulator.
- No combinational path from `in_valid` or `in_data` to any output. `in_ready` depends combinationally on `out_ready` only.

## Structure
- Package `imm_pkg`:
  - `DATA_W`, `IMM_W`, `MAX_CHUNKS`=3
  - range constants `IMM1_MIN`/`IMM1_MAX` (±2^13) and `IMM2_MIN`/`IMM2_MAX` (±2^27)
  - state enum {`ST_IDLE`, `ST_EMIT`}
- Sub-module `imm_fit_check`: combinational. Takes `in_data` and produces N plus the three candidate chunk values. It is instantiated once in `imm_chunker` and unit-tested separately.

## Test plan
- 0x00001FFF, `out_ready`=1: one chunk, 0x1FFF, with `first`=`last`=1 and `count`=1, in the cycle after acceptance.
- 0xFFFFE000: one chunk, 0x2000. Input 0x00002000: two chunks, 0x0000 then 0x2000, `count`=2.
- 0x80000000: chunks 0x3FF8, 0x0000, 0x0000. 0x12345678: chunks 0x0001, 0x08D1, 0x1678. The bench reassembles both and checks them against the input.
- Backpressure: 0x12345678 with `out_ready` low for 3 cycles on chunk 2. 0x08D1 holds stable, `in_ready`=0, and no chunk is lost or duplicated.
- Back-to-back: 0x00000005 then 0xFFFFFFFF with `in_valid` and `out_ready` held at 1. Outputs are 0x0005 then 0x3FFF on consecutive cycles, each with `first`=`last`=1, and no idle cycle between them.
- Reset asserted during chunk 2 of 0x80000000: `out_valid` drops to 0 immediately, and after release `in_ready`=1. A following 0x00000003 yields a single chunk, 0x0003, with `first`=1.
